// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the ROM loader: FSM states, framing bytes
// and the internal widths of the length, checksum and idle-timer fields.
package rom_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    CSUM,
    RESP
  } state_e;

  localparam logic [7:0] SYNC = 8'h55;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;

  localparam int LEN_W   = 17;
  localparam int CSUM_W  = 8;
  localparam int TIMER_W = 24;

endpackage

// File: rtl/rom_loader_timeout.sv
// Inter-byte idle timer: reloads on restart, counts down while enabled and
// flags expiry once the full TIMEOUT window has elapsed.
module loader_timeout
  import rom_loader_pkg::*;
#(
  parameter logic [TIMER_W-1:0] TIMEOUT = 24'd1000000
) (
  input  logic clockgb,
  input  logic reset,
  input  logic restart_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = TIMEOUT;
    end else if (enable_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge clockgb or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The owner only samples this in states entered through a restart.
  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/rom_loader.sv
// Receives a framed ROM image over the UART byte stream, streams the payload
// into SRAM one handshake at a time and answers with ACK or NAK.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter logic [15:0]        BASE    = 16'h0000,
  parameter logic [LEN_W-1:0]   MAX_LEN = 17'h08000,
  parameter logic [TIMER_W-1:0] TIMEOUT = 24'd1000000
) (
  input  logic        clockgb,
  input  logic        reset,
  input  logic        prog,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] sram_address,
  output logic [7:0]  sram_wdata,
  output logic        sram_store,
  input  logic        sram_ready,
  output logic        busy,
  output logic        done,
  output logic        error
);

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d, count_q, count_d;
  logic [LEN_W-1:0]    new_len, count_inc;
  logic [CSUM_W-1:0]   sum_q, sum_d;
  logic [15:0]         addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d, tx_data_q, tx_data_d;
  logic                done_q, done_d, error_q, error_d;
  logic                timer_en, expired;

  assign timer_en  = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                     (state_q == DATA)   || (state_q == CSUM);
  assign new_len   = {1'b0, len_q[15:8], rx_data};
  assign count_inc = count_q + LEN_W'(1);

  loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clockgb   (clockgb),
    .reset     (reset),
    .restart_i (rx_valid),
    .enable_i  (timer_en),
    .expired_o (expired)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    count_d   = count_q;
    sum_d     = sum_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    tx_data_d = tx_data_q;
    done_d    = done_q;
    error_d   = error_q;
    case (state_q)
      IDLE: begin
        if (prog && rx_valid && (rx_data == SYNC)) begin
          state_d = LEN_HI;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end
      LEN_HI: begin
        if (rx_valid) begin
          len_d   = {1'b0, rx_data, 8'h00};
          state_d = LEN_LO;
        end else if (expired) begin
          state_d   = RESP;
          tx_data_d = NAK;
        end
      end
      LEN_LO: begin
        if (rx_valid) begin
          len_d = new_len;
          if ((new_len == '0) || (new_len > MAX_LEN)) begin
            state_d   = RESP;
            tx_data_d = NAK;
          end else begin
            count_d = '0;
            sum_d   = '0;
            state_d = DATA;
          end
        end else if (expired) begin
          state_d   = RESP;
          tx_data_d = NAK;
        end
      end
      DATA: begin
        if (rx_valid) begin
          wdata_d = rx_data;
          addr_d  = BASE + count_q[15:0];
          sum_d   = sum_q + rx_data;
          state_d = WRITE;
        end else if (expired) begin
          state_d   = RESP;
          tx_data_d = NAK;
        end
      end
      WRITE: begin
        if (sram_ready) begin
          count_d = count_inc;
          state_d = (count_inc == len_q) ? CSUM : DATA;
        end
        // A byte arriving while the write is pending has nowhere to go.
        if (rx_valid) begin
          state_d   = RESP;
          tx_data_d = NAK;
        end
      end
      CSUM: begin
        if (rx_valid) begin
          state_d   = RESP;
          tx_data_d = (rx_data == sum_q) ? ACK : NAK;
        end else if (expired) begin
          state_d   = RESP;
          tx_data_d = NAK;
        end
      end
      RESP: begin
        if (tx_ready) begin
          done_d  = done_q  | (tx_data_q == ACK);
          error_d = error_q | (tx_data_q != ACK);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Leaving programming mode aborts silently, except a response already owed.
    if (!prog && (state_q != IDLE) && (state_q != RESP)) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clockgb or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      count_q   <= '0;
      sum_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      tx_data_q <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      count_q   <= count_d;
      sum_q     <= sum_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      tx_data_q <= tx_data_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign tx_data      = tx_data_q;
  assign tx_valid     = (state_q == RESP);
  assign sram_address = addr_q;
  assign sram_wdata   = wdata_q;
  assign sram_store   = (state_q == WRITE);
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_rom_loader.sv
// Randomized and directed frames against a byte-level model of the framing
// rules: expected SRAM writes, response byte and sticky flags.
module tb_rom_loader;

  localparam logic [15:0] TB_BASE = 16'hFFFE;
  localparam logic [7:0]  B_SYNC  = 8'h55;
  localparam logic [7:0]  B_ACK   = 8'h06;
  localparam logic [7:0]  B_NAK   = 8'h15;

  logic        clockgb = 1'b0;
  logic        reset = 1'b0;
  logic        prog = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] sram_address;
  logic [7:0]  sram_wdata;
  logic        sram_store;
  logic        sram_ready;
  logic        busy, done, error;

  int          testsRun = 0;
  int          testsFailed = 0;
  int          txValidCycles = 0;
  bit          randomReady = 1'b0;
  logic        forcedSram = 1'b1;
  logic        forcedTx = 1'b1;
  logic [15:0] wrAddrQ [$];
  logic [7:0]  wrDataQ [$];
  logic [7:0]  respQ [$];
  logic [7:0]  payload [0:63];

  rom_loader #(
    .BASE    (TB_BASE),
    .MAX_LEN (17'h08000),
    .TIMEOUT (24'd100)
  ) dut (
    .clockgb      (clockgb),
    .reset        (reset),
    .prog         (prog),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .sram_address (sram_address),
    .sram_wdata   (sram_wdata),
    .sram_store   (sram_store),
    .sram_ready   (sram_ready),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 clockgb = ~clockgb;

  // Ready generator: either forced levels or random stalls of at most two cycles.
  initial begin
    int sramLow;
    int txLow;
    sramLow = 0;
    txLow = 0;
    sram_ready = 1'b1;
    tx_ready = 1'b1;
    forever begin
      @(posedge clockgb);
      #1;
      if (randomReady) begin
        if (sramLow >= 2 || $urandom_range(0, 2) != 0) begin
          sram_ready = 1'b1;
          sramLow = 0;
        end else begin
          sram_ready = 1'b0;
          sramLow++;
        end
        if (txLow >= 2 || $urandom_range(0, 2) != 0) begin
          tx_ready = 1'b1;
          txLow = 0;
        end else begin
          tx_ready = 1'b0;
          txLow++;
        end
      end else begin
        sram_ready = forcedSram;
        tx_ready = forcedTx;
      end
    end
  end

  // Handshake monitor, sampled half a cycle away from the active edge.
  always @(negedge clockgb) begin
    if (sram_store && sram_ready) begin
      wrAddrQ.push_back(sram_address);
      wrDataQ.push_back(sram_wdata);
    end
    if (tx_valid && tx_ready) respQ.push_back(tx_data);
    if (tx_valid) txValidCycles++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int gap);
    @(posedge clockgb);
    #1;
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clockgb);
    #1;
    rx_valid = 1'b0;
    repeat (gap) @(posedge clockgb);
  endtask

  task automatic waitResp(input string tag, input int rStart, input int budget,
                          output int cyc, output logic [7:0] got);
    cyc = 0;
    got = 8'h00;
    while (respQ.size() <= rStart && cyc < budget) begin
      @(posedge clockgb);
      #2;
      cyc++;
    end
    checkOutput({tag, "_resp_seen"}, 64'(respQ.size() > rStart), 64'd1);
    if (respQ.size() > rStart) got = respQ[rStart];
  endtask

  task automatic compareWrites(input string tag, input int wStart, input int expCount);
    int n;
    logic [15:0] expAddr;
    n = wrAddrQ.size() - wStart;
    checkOutput({tag, "_wr_count"}, 64'(n), 64'(expCount));
    for (int i = 0; i < n && i < expCount; i++) begin
      expAddr = TB_BASE + 16'(i);
      checkOutput({tag, "_wr_addr"}, 64'(wrAddrQ[wStart + i]), 64'(expAddr));
      checkOutput({tag, "_wr_data"}, 64'(wrDataQ[wStart + i]), 64'(payload[i]));
    end
  endtask

  // csumSel < 0 sends the correct checksum, otherwise its low byte verbatim.
  task automatic runFrame(input string tag, input logic [15:0] len,
                          input int csumSel, input int gap);
    logic [7:0] sum;
    logic [7:0] csum;
    logic [7:0] expResp;
    logic [7:0] got;
    int wStart;
    int rStart;
    int cyc;
    int expCount;
    wStart = wrAddrQ.size();
    rStart = respQ.size();
    sum = 8'h00;
    applyStimulus(B_SYNC, gap);
    applyStimulus(len[15:8], gap);
    applyStimulus(len[7:0], gap);
    if (len == 16'h0000 || int'(len) > 32768) begin
      expResp = B_NAK;
      expCount = 0;
    end else begin
      for (int i = 0; i < int'(len); i++) begin
        sum = sum + payload[i];
        applyStimulus(payload[i], gap);
      end
      csum = (csumSel < 0) ? sum : csumSel[7:0];
      applyStimulus(csum, gap);
      expResp = (csum == sum) ? B_ACK : B_NAK;
      expCount = int'(len);
    end
    waitResp(tag, rStart, 200, cyc, got);
    checkOutput({tag, "_tx_data"}, 64'(got), 64'(expResp));
    checkOutput({tag, "_done"}, 64'(done), 64'(expResp == B_ACK));
    checkOutput({tag, "_error"}, 64'(error), 64'(expResp != B_ACK));
    compareWrites(tag, wStart, expCount);
  endtask

  initial begin
    int wStart;
    int rStart;
    int cyc;
    int txBefore;
    logic [7:0] got;
    logic [15:0] rlen;

    #2 reset = 1'b1;
    repeat (3) @(posedge clockgb);
    #1;
    checkOutput("reset_outputs",
                {27'd0, tx_data, tx_valid, sram_address, sram_wdata, sram_store, busy, done, error},
                64'd0);
    @(negedge clockgb);
    reset = 1'b0;
    prog = 1'b1;

    payload[0] = 8'hAA;
    payload[1] = 8'hBB;
    payload[2] = 8'hCC;
    runFrame("plan_ack", 16'd3, -1, 2);
    runFrame("plan_bad_csum", 16'd3, 0, 2);
    runFrame("len_zero", 16'h0000, -1, 2);
    runFrame("len_8001", 16'h8001, -1, 2);
    runFrame("after_bad_len", 16'd3, -1, 2);

    // Overrun: a second payload byte arrives while SRAM is stalled.
    forcedSram = 1'b0;
    wStart = wrAddrQ.size();
    rStart = respQ.size();
    applyStimulus(B_SYNC, 1);
    applyStimulus(8'h00, 1);
    applyStimulus(8'h03, 1);
    applyStimulus(8'h11, 2);
    #1;
    checkOutput("overrun_store_high", 64'(sram_store), 64'd1);
    applyStimulus(8'h22, 0);
    checkOutput("overrun_store_low", 64'(sram_store), 64'd0);
    waitResp("overrun", rStart, 50, cyc, got);
    checkOutput("overrun_tx_data", 64'(got), 64'(B_NAK));
    compareWrites("overrun", wStart, 0);
    forcedSram = 1'b1;
    repeat (3) @(posedge clockgb);
    checkOutput("overrun_error", 64'(error), 64'd1);

    // Timeout: frame stalls after one payload byte of two.
    payload[0] = 8'h42;
    wStart = wrAddrQ.size();
    rStart = respQ.size();
    applyStimulus(B_SYNC, 1);
    applyStimulus(8'h00, 1);
    applyStimulus(8'h02, 1);
    applyStimulus(8'h42, 0);
    waitResp("timeout", rStart, 300, cyc, got);
    checkOutput("timeout_tx_data", 64'(got), 64'(B_NAK));
    checkOutput("timeout_not_early", 64'(cyc >= 90), 64'd1);
    checkOutput("timeout_not_late", 64'(cyc <= 120), 64'd1);
    checkOutput("timeout_error", 64'(error), 64'd1);
    compareWrites("timeout", wStart, 1);

    // prog drops mid-DATA: silent abort, SYNC already cleared the flags.
    rStart = respQ.size();
    applyStimulus(B_SYNC, 2);
    applyStimulus(8'h00, 2);
    applyStimulus(8'h05, 2);
    applyStimulus(8'h01, 3);
    applyStimulus(8'h02, 3);
    @(posedge clockgb);
    #1;
    prog = 1'b0;
    txBefore = txValidCycles;
    @(posedge clockgb);
    #1;
    checkOutput("progdrop_busy", 64'(busy), 64'd0);
    repeat (20) @(posedge clockgb);
    checkOutput("progdrop_no_tx_valid", 64'(txValidCycles - txBefore), 64'd0);
    checkOutput("progdrop_no_resp", 64'(respQ.size() - rStart), 64'd0);
    checkOutput("progdrop_flags", {62'd0, done, error}, 64'd0);
    prog = 1'b1;

    // Asynchronous reset while a write is pending.
    forcedSram = 1'b0;
    applyStimulus(B_SYNC, 1);
    applyStimulus(8'h00, 1);
    applyStimulus(8'h02, 1);
    applyStimulus(8'h77, 2);
    #1;
    checkOutput("midwrite_store", {47'd0, sram_store, sram_address}, {47'd1, TB_BASE});
    checkOutput("midwrite_wdata", 64'(sram_wdata), 64'h77);
    @(negedge clockgb);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midwrite_reset_outputs",
                {27'd0, tx_data, tx_valid, sram_address, sram_wdata, sram_store, busy, done, error},
                64'd0);
    @(negedge clockgb);
    reset = 1'b0;
    forcedSram = 1'b1;
    repeat (2) @(posedge clockgb);

    // Random frames with random SRAM and transmitter stalls.
    randomReady = 1'b1;
    for (int f = 0; f < 8; f++) begin
      rlen = 16'($urandom_range(1, 12));
      for (int i = 0; i < 12; i++) payload[i] = 8'($urandom_range(0, 255));
      runFrame("random", rlen, ($urandom_range(0, 1) == 1) ? -1 : int'($urandom_range(0, 255)), 6);
    end
    randomReady = 1'b0;

    repeat (4) @(posedge clockgb);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
